bnn_dot_seq: RTL and testbench

Multi-word binarized dot-product sequencer wrapped around the 32-bit XNOR-popcount unit (`bnn`). It accepts a job of `len` operand-word pairs over a valid/ready stream and pipelines each pair through XNOR-popcount. It accumulates the counts and applies a sign/threshold activation, so the core can offload one full BNN neuron evaluation per job instead of one word per instruction.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/bnn.sv | 26 ++
 rtl/bnn_dot_seq.sv | 154 +++++++++++++++
 tb/tb_bnn_dot_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized dot-product sequencer.
//   BNN_WORD_W      : operand word width fed to the XNOR-popcount unit
//   BNN_POP_W       : popcount width for one word (0..32 needs 6 bits)
//   bnn_seq_state_t : sequencer FSM states
package bnn_pkg;

  localparam int BNN_WORD_W = 32;
  localparam int BNN_POP_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bnn_seq_state_t;

endpackage

// File: rtl/bnn.sv
// Combinational 32-bit XNOR-popcount unit.
// Counts the bit positions where the two operand words agree. This is
// the binarized (+1/-1) multiply-accumulate of one word pair.
// Ports:
//   a, b   : operand words
//   result : number of matching bit positions (0..32)
module bnn
  import bnn_pkg::*;
(
  input  logic [BNN_WORD_W-1:0] a,
  input  logic [BNN_WORD_W-1:0] b,
  output logic [BNN_POP_W-1:0]  result
);

  logic [BNN_WORD_W-1:0] match;

  assign match = ~(a ^ b);

  always_comb begin
    result = '0;
    for (int i = 0; i < BNN_WORD_W; i++) begin
      result = result + {{(BNN_POP_W-1){1'b0}}, match[i]};
    end
  end

endmodule

// File: rtl/bnn_dot_seq.sv
// Multi-word binarized dot-product sequencer.
// A job of `len` operand-word pairs is accepted on `start`. Each pair
// passes through the XNOR-popcount unit into a one-stage pipeline
// register (pc_q/pc_v). The counts are summed into `acc`, and
// `act = acc >= threshold` is raised alongside the one-cycle `done`.
// Ports:
//   clk, reset_n      : clock (rising edge), async active-low reset
//   start, len,       : job request, and the word count and threshold
//   threshold           sampled when the request is accepted in IDLE
//   abort             : synchronous cancel, wins over everything else
//   op_a, op_b,       : operand pair stream
//   op_valid, op_ready
//   busy              : sequencer not IDLE
//   done              : one-cycle completion pulse
//   acc, act          : result; held until the next accepted start/abort
//   state_dbg         : current FSM state
//
// Handshake: a pair is consumed on a rising edge where op_valid and
// op_ready are both 1. op_ready depends only on state and abort, never
// on op_valid. A producer may hold op_valid low for any number of cycles.
// Pairs presented while op_ready is 0 are left untouched.
module bnn_dot_seq
  import bnn_pkg::*;
#(
  parameter  int LEN_W = 8,
  localparam int ACC_W = LEN_W + 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [ACC_W-1:0]      threshold,
  input  logic                  abort,
  input  logic [BNN_WORD_W-1:0] op_a,
  input  logic [BNN_WORD_W-1:0] op_b,
  input  logic                  op_valid,
  output logic                  op_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_W-1:0]      acc,
  output logic                  act,
  output bnn_seq_state_t        state_dbg
);

  bnn_seq_state_t       state, state_nxt;
  logic [LEN_W-1:0]     remaining;
  logic [BNN_POP_W-1:0] pop;
  logic [BNN_POP_W-1:0] pc_q;
  logic                 pc_v;
  logic [ACC_W-1:0]     thr_q;
  logic [ACC_W-1:0]     acc_sum;
  logic                 accept;
  logic                 xfer;
  logic                 last_xfer;

  bnn u_bnn (
    .a      (op_a),
    .b      (op_b),
    .result (pop)
  );

  assign accept    = (state == IDLE) && start && !abort;
  assign xfer      = op_valid && op_ready;
  assign last_xfer = xfer && (remaining == LEN_W'(1));

  // Running sum including the popcount currently sitting in pc_q. In DRAIN
  // this is the final value, which lets `act` be registered together with
  // the last accumulate so both are valid during the DONE cycle.
  assign acc_sum = pc_v ? (acc + ACC_W'(pc_q)) : acc;

  assign state_dbg = state;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    // Dropping ready during abort keeps the cancelled cycle from looking
    // like a consumed pair to the producer.
    op_ready  = (state == RUN) && !abort;
    busy      = (state != IDLE);
    done      = (state == DONE);
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = (len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (last_xfer) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: state_nxt = DONE;
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      act       <= 1'b0;
      pc_q      <= '0;
      pc_v      <= 1'b0;
      remaining <= '0;
      thr_q     <= '0;
    end else if (abort) begin
      // The in-flight popcount is dropped along with the partial sum.
      acc       <= '0;
      act       <= 1'b0;
      pc_v      <= 1'b0;
      remaining <= '0;
    end else begin
      acc  <= acc_sum;
      pc_v <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            remaining <= len;
            thr_q     <= threshold;
            // An empty job goes straight to DONE with acc = 0, so its
            // activation is simply 0 >= threshold.
            act       <= (len == '0) && (threshold == '0);
          end
        end
        RUN: begin
          if (xfer) begin
            pc_q      <= pop;
            pc_v      <= 1'b1;
            remaining <= remaining - LEN_W'(1);
          end
        end
        DRAIN: begin
          act <= (acc_sum >= thr_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_dot_seq.sv
// Directed testbench for bnn_dot_seq. Expected results come from a
// word-level model: sum over the job of the count of matching bits,
// then compare against the threshold. Each result is queued when a job
// is launched and checked whenever the DUT pulses done.
module tb_bnn_dot_seq;

  localparam int LEN_W = 8;
  localparam int ACC_W = LEN_W + 6;

  // ------------------------------------------------ clock / reset block
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [ACC_W-1:0] threshold = '0;
  logic [31:0]      op_a = '0;
  logic [31:0]      op_b = '0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] acc;
  logic             act;
  logic [1:0]       state_dbg;

  bnn_dot_seq #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (len),
    .threshold (threshold),
    .abort     (abort),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .busy      (busy),
    .done      (done),
    .acc       (acc),
    .act       (act),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;

  logic [ACC_W:0] exp_q[$];
  logic [ACC_W:0] exp_e;
  logic [31:0]    pa[256];
  logic [31:0]    pb[256];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // --------------------------------------------------------------- model
  function automatic int match_count(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    for (int i = 0; i < 32; i++) begin
      if (a[i] == b[i]) n++;
    end
    return n;
  endfunction

  task automatic push_exp(input int n, input int thr);
    int s = 0;
    logic [ACC_W-1:0] sv;
    logic [ACC_W-1:0] tv;
    for (int i = 0; i < n; i++) s += match_count(pa[i], pb[i]);
    sv = ACC_W'(s);
    tv = ACC_W'(thr);
    exp_q.push_back({(sv >= tv), sv});
  endtask

  // ---------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (op_valid && op_ready) xfer_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0 acc=%0d", acc);
        end else begin
          exp_e = exp_q.pop_front();
          check("done_acc", 32'(acc), 32'(exp_e[ACC_W-1:0]));
          check("done_act", 32'(act), 32'(exp_e[ACC_W]));
        end
      end
      check("ready_implies_busy", 32'(op_ready && !busy), 32'd0);
    end
  end

  // ------------------------------------------------------ driver tasks
  // All tasks start and end 1ns after a rising edge.
  task automatic do_start(input int n, input int thr);
    len = LEN_W'(n);
    threshold = ACC_W'(thr);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Presents pairs pa/pb[0..n-1]. gap: valid low every other cycle.
  // poke_at: when that many pairs are in, pulse start (poke_abort=0) or
  // abort (poke_abort=1) for one cycle; an abort ends the feed.
  task automatic feed(input int n, input bit gap, input int poke_at, input bit poke_abort,
                      output int got, output bit ready_dropped);
    int  guard = 0;
    bit  rdy;
    bit  poked = 1'b0;
    bit  stop = 1'b0;
    got = 0;
    ready_dropped = 1'b0;
    while (got < n && guard < 2000 && !stop) begin
      if (got == poke_at && !poked) begin
        poked = 1'b1;
        if (poke_abort) abort = 1'b1;
        else begin
          start = 1'b1;
          len = LEN_W'(1);
          threshold = '0;
        end
      end
      if (abort) op_valid = 1'b0;
      else begin
        op_valid = !(gap && guard[0]);
        op_a = pa[got];
        op_b = pb[got];
      end
      @(negedge clk);
      rdy = op_ready;
      if (!rdy) ready_dropped = 1'b1;
      @(posedge clk);
      if (op_valid && rdy) got++;
      #1;
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        stop = 1'b1;
      end
      guard++;
    end
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    bit seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // ----------------------------------------------------------- stimulus
  initial begin
    int  got;
    bit  dropped;
    int  x0;

    // reset
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(op_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_act", 32'(act), 0);
    next_edge();
    next_edge();
    reset_n = 1'b1;
    next_edge();

    // T1: one all-ones pair, thr 32
    pa[0] = 32'hFFFF_FFFF; pb[0] = 32'hFFFF_FFFF;
    push_exp(1, 32);
    do_start(1, 32);
    feed(1, 1'b0, -1, 1'b0, got, dropped);
    check("t1_xfers", got, 1);
    @(negedge clk);
    check("t1_drain_done", 32'(done), 0);
    check("t1_drain_ready", 32'(op_ready), 0);
    check("t1_drain_busy", 32'(busy), 1);
    @(negedge clk);
    check("t1_done", 32'(done), 1);
    check("t1_acc", 32'(acc), 32);
    check("t1_act", 32'(act), 1);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_done", 32'(done), 0);
    check("t1_acc_held", 32'(acc), 32);
    next_edge();

    // T2: three pairs, 32+0+16 = 48 < 49; extra pair held during drain
    pa[0] = 32'h0;        pb[0] = 32'h0;
    pa[1] = 32'h0;        pb[1] = 32'hFFFF_FFFF;
    pa[2] = 32'h0000_FFFF; pb[2] = 32'h0;
    push_exp(3, 49);
    x0 = xfer_cnt;
    do_start(3, 49);
    feed(3, 1'b0, -1, 1'b0, got, dropped);
    check("t2_feed", got, 3);
    op_valid = 1'b1; op_a = 32'hDEAD_BEEF; op_b = 32'hDEAD_BEEF;
    wait_done(10);
    check("t2_acc", 32'(acc), 48);
    check("t2_act", 32'(act), 0);
    next_edge();
    next_edge();
    op_valid = 1'b0;
    check("t2_xfer_count", xfer_cnt - x0, 3);

    // T3: four identical pairs with valid gaps, 4*32 = 128
    for (int i = 0; i < 4; i++) begin pa[i] = 32'h1234_5678; pb[i] = 32'h1234_5678; end
    push_exp(4, 0);
    do_start(4, 0);
    feed(4, 1'b1, -1, 1'b0, got, dropped);
    check("t3_feed", got, 4);
    check("t3_ready_held", 32'(dropped), 0);
    @(negedge clk);
    check("t3_ready_after", 32'(op_ready), 0);
    wait_done(10);
    check("t3_acc", 32'(acc), 128);
    next_edge();

    // T4: empty job, thr 0
    x0 = xfer_cnt;
    push_exp(0, 0);
    op_valid = 1'b1;
    do_start(0, 0);
    @(negedge clk);
    check("t4_done", 32'(done), 1);
    check("t4_ready", 32'(op_ready), 0);
    check("t4_acc", 32'(acc), 0);
    check("t4_act", 32'(act), 1);
    next_edge();
    op_valid = 1'b0;
    check("t4_no_xfer", xfer_cnt - x0, 0);

    // T5: start mid-RUN ignored; 5 * 16 = 80 >= 80
    for (int i = 0; i < 5; i++) begin pa[i] = 32'h0F0F_0F0F; pb[i] = 32'h0; end
    push_exp(5, 80);
    do_start(5, 80);
    feed(5, 1'b0, 2, 1'b0, got, dropped);
    check("t5_feed", got, 5);
    wait_done(10);
    check("t5_acc", 32'(acc), 80);
    check("t5_act", 32'(act), 1);
    @(negedge clk);
    check("t5_idle_after", 32'(busy), 0);
    next_edge();

    // T6: abort after 2 of 5 transfers
    for (int i = 0; i < 5; i++) begin pa[i] = 32'h0; pb[i] = 32'h0; end
    x0 = xfer_cnt;
    do_start(5, 0);
    feed(5, 1'b0, 2, 1'b1, got, dropped);
    check("t6_xfers", xfer_cnt - x0, 2);
    @(negedge clk);
    check("t6_busy", 32'(busy), 0);
    check("t6_acc", 32'(acc), 0);
    check("t6_act", 32'(act), 0);
    check("t6_done", 32'(done), 0);
    for (int k = 0; k < 6; k++) next_edge();

    // T7: start together with abort in IDLE
    start = 1'b1; abort = 1'b1; len = LEN_W'(3); threshold = '0;
    next_edge();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("t7_busy", 32'(busy), 0);
    check("t7_ready", 32'(op_ready), 0);
    next_edge();

    // T8: longest job, 255 * 32 = 8160 >= 8160
    for (int i = 0; i < 255; i++) begin pa[i] = 32'(i * 32'h0101_0101); pb[i] = pa[i]; end
    push_exp(255, 8160);
    do_start(255, 8160);
    feed(255, 1'b0, -1, 1'b0, got, dropped);
    check("t8_feed", got, 255);
    wait_done(10);
    check("t8_acc", 32'(acc), 8160);
    check("t8_act", 32'(act), 1);
    next_edge();

    // T9: same job, reset pulsed mid-RUN
    do_start(255, 8160);
    feed(100, 1'b0, -1, 1'b0, got, dropped);
    #3;
    reset_n = 1'b0;
    #1;
    check("t9_busy", 32'(busy), 0);
    check("t9_ready", 32'(op_ready), 0);
    check("t9_done", 32'(done), 0);
    check("t9_acc", 32'(acc), 0);
    check("t9_act", 32'(act), 0);
    next_edge();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) next_edge();
    @(negedge clk);
    check("t9_still_idle", 32'(busy), 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
